// File: rtl/hv_bundler.sv
// hv_bundler: majority-vote bundling stage for hypervectors.
// Accumulates accepted DIM+1-bit vectors into per-bit saturating signed
// counters; on the last vector of a bundle it spends one DRAIN cycle
// thresholding the counters into `result`, pulses `result_valid`, and clears.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous abort/flush of the current bundle
//   valid_in        data_in valid this cycle
//   last_in         accepted vector is the final one of the bundle
//   data_in         permuted hypervector
//   ready_in        block can accept a vector this cycle
//   result_valid    one-cycle pulse, result holds a new bundle
//   result          bundled hypervector, held until the next bundle
//   num_out         vector count of the last completed bundle
//   sat_flag        a counter clipped during the last completed bundle
module hv_bundler #(
   parameter int unsigned DIM   = 1023,
   parameter int unsigned CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           valid_in,
   input  logic           last_in,
   input  logic [DIM:0]   data_in,
   output logic           ready_in,
   output logic           result_valid,
   output logic [DIM:0]   result,
   output logic [15:0]    num_out,
   output logic           sat_flag
);

   localparam int unsigned W = DIM + 1;
   localparam logic signed [CNT_W-1:0] CNT_MAX = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic signed [CNT_W-1:0] CNT_MIN = -CNT_MAX;
   localparam logic signed [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {ACC, DRAIN} state_t;

   state_t                  state, state_nxt;
   logic signed [CNT_W-1:0] cnt     [W];
   logic signed [CNT_W-1:0] cnt_nxt [W];
   logic [DIM:0]            tie_v;
   logic [DIM:0]            result_nxt;
   logic [15:0]             count;
   logic                    sat_pend;
   logic                    first;
   logic                    clip_any;
   logic                    accept;

   assign accept = valid_in && ready_in && !clear;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nxt;
   end

   // Next-state: DRAIN lasts exactly one cycle; clear always returns to ACC
   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (accept && last_in) state_nxt = DRAIN;
         DRAIN:   state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
      if (clear) state_nxt = ACC;
   end

   // Saturating up/down step per bit, plus clip detection
   always_comb begin
      clip_any = 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
         cnt_nxt[i] = cnt[i];
         if (data_in[i]) begin
            if (cnt[i] == CNT_MAX) clip_any = 1'b1;
            else                   cnt_nxt[i] = cnt[i] + CNT_ONE;
         end else begin
            if (cnt[i] == CNT_MIN) clip_any = 1'b1;
            else                   cnt_nxt[i] = cnt[i] - CNT_ONE;
         end
      end
   end

   // Threshold: sign decides, zero falls back to the first vector's bit
   always_comb begin
      result_nxt = '0;
      for (int unsigned i = 0; i < W; i++) begin
         if (cnt[i] == '0) result_nxt[i] = tie_v[i];
         else              result_nxt[i] = ~cnt[i][CNT_W-1];
      end
   end

   // Accumulation datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < W; i++) cnt[i] <= '0;
         tie_v        <= '0;
         count        <= '0;
         sat_pend     <= 1'b0;
         first        <= 1'b1;
         result       <= '0;
         result_valid <= 1'b0;
         num_out      <= '0;
         sat_flag     <= 1'b0;
         ready_in     <= 1'b1;
      end else begin
         result_valid <= (state == DRAIN) && !clear;
         ready_in     <= (state_nxt == ACC);
         if (clear || state == DRAIN) begin
            if (!clear) begin
               result   <= result_nxt;
               num_out  <= count;
               sat_flag <= sat_pend;
            end
            for (int unsigned i = 0; i < W; i++) cnt[i] <= '0;
            count    <= '0;
            sat_pend <= 1'b0;
            first    <= 1'b1;
         end else if (accept) begin
            for (int unsigned i = 0; i < W; i++) cnt[i] <= cnt_nxt[i];
            if (count != 16'hFFFF) count <= count + 16'd1;
            sat_pend <= sat_pend | clip_any;
            if (first) tie_v <= data_in;
            first <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hv_bundler.sv
// tb_hv_bundler: directed self-checking bench for hv_bundler (DIM=7, CNT_W=4).
module tb_hv_bundler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        valid_in = 1'b0;
   logic        last_in = 1'b0;
   logic [7:0]  data_in = '0;
   logic        ready_in;
   logic        result_valid;
   logic [7:0]  result;
   logic [15:0] num_out;
   logic        sat_flag;

   int tests = 0;
   int fails = 0;

   hv_bundler #(.DIM(7), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
      .last_in(last_in), .data_in(data_in), .ready_in(ready_in),
      .result_valid(result_valid), .result(result), .num_out(num_out),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic l, input logic [7:0] d);
      valid_in = v;
      last_in  = l;
      data_in  = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready_in); end
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got %b exp 0", result_valid); end
      tests++; if (result !== 8'h00) begin fails++; $display("FAIL reset_result got %h exp 00", result); end
      tests++; if (num_out !== 16'd0) begin fails++; $display("FAIL reset_num got %0d exp 0", num_out); end
      tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset_sat got %b exp 0", sat_flag); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      drive(1, 0, 8'hF0); tick();
      drive(1, 0, 8'hCC); tick();
      drive(1, 1, 8'hAA); tick();
      drive(0, 0, 8'h00);
      tests++; if (ready_in !== 1'b0) begin fails++; $display("FAIL basic_bubble got %b exp 0", ready_in); end
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL basic_rv_early got %b exp 0", result_valid); end
      tick();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL basic_rv got %b exp 1", result_valid); end
      tests++; if (result !== 8'hE8) begin fails++; $display("FAIL basic_result got %h exp e8", result); end
      tests++; if (num_out !== 16'd3) begin fails++; $display("FAIL basic_num got %0d exp 3", num_out); end
      tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL basic_sat got %b exp 0", sat_flag); end
      tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL basic_ready_back got %b exp 1", ready_in); end
      tick();
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL basic_rv_pulse got %b exp 0", result_valid); end
      tests++; if (result !== 8'hE8) begin fails++; $display("FAIL basic_hold got %h exp e8", result); end
   endtask

   task automatic test_tie();
      drive(1, 0, 8'h0F); tick();
      drive(1, 1, 8'hF0); tick();
      drive(0, 0, 8'h00); tick();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL tie_rv got %b exp 1", result_valid); end
      tests++; if (result !== 8'h0F) begin fails++; $display("FAIL tie_result got %h exp 0f", result); end
      tests++; if (num_out !== 16'd2) begin fails++; $display("FAIL tie_num got %0d exp 2", num_out); end
      tick();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 10; i++) begin drive(1, 0, 8'hFF); tick(); end
      for (int i = 0; i < 8; i++) begin drive(1, (i == 7), 8'h00); tick(); end
      drive(0, 0, 8'h00); tick();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL sat_rv got %b exp 1", result_valid); end
      tests++; if (result !== 8'h00) begin fails++; $display("FAIL sat_result got %h exp 00", result); end
      tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat_flag got %b exp 1", sat_flag); end
      tests++; if (num_out !== 16'd18) begin fails++; $display("FAIL sat_num got %0d exp 18", num_out); end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 8'h5A); tick();
      tests++; if (ready_in !== 1'b0) begin fails++; $display("FAIL b2b_bubble got %b exp 0", ready_in); end
      // Held through the bubble; must only be taken once ready returns
      drive(1, 1, 8'h33); tick();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL b2b_rv1 got %b exp 1", result_valid); end
      tests++; if (result !== 8'h5A) begin fails++; $display("FAIL b2b_result1 got %h exp 5a", result); end
      tests++; if (num_out !== 16'd1) begin fails++; $display("FAIL b2b_num1 got %0d exp 1", num_out); end
      tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL b2b_sat1 got %b exp 0", sat_flag); end
      tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b exp 1", ready_in); end
      tick();
      drive(0, 0, 8'h00);
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL b2b_rv_gap got %b exp 0", result_valid); end
      tests++; if (ready_in !== 1'b0) begin fails++; $display("FAIL b2b_bubble2 got %b exp 0", ready_in); end
      tick();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL b2b_rv2 got %b exp 1", result_valid); end
      tests++; if (result !== 8'h33) begin fails++; $display("FAIL b2b_result2 got %h exp 33", result); end
      tests++; if (num_out !== 16'd1) begin fails++; $display("FAIL b2b_num2 got %0d exp 1", num_out); end
      tick();
   endtask

   task automatic test_clear();
      drive(1, 0, 8'h11); tick();
      drive(1, 1, 8'h22); clear = 1'b1; tick();
      clear = 1'b0; drive(0, 0, 8'h00);
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL clr_rv got %b exp 0", result_valid); end
      tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL clr_ready got %b exp 1", ready_in); end
      tick();
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL clr_rv2 got %b exp 0", result_valid); end
      tests++; if (result !== 8'h33) begin fails++; $display("FAIL clr_hold got %h exp 33", result); end
      drive(1, 1, 8'h3C); tick();
      drive(0, 0, 8'h00); tick();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL clr_rv3 got %b exp 1", result_valid); end
      tests++; if (result !== 8'h3C) begin fails++; $display("FAIL clr_result got %h exp 3c", result); end
      tests++; if (num_out !== 16'd1) begin fails++; $display("FAIL clr_num got %0d exp 1", num_out); end
      tick();
      // clear during DRAIN cancels the pending output
      drive(1, 1, 8'h77); tick();
      drive(0, 0, 8'h00); clear = 1'b1; tick();
      clear = 1'b0;
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL clr_drain_rv got %b exp 0", result_valid); end
      tests++; if (result !== 8'h3C) begin fails++; $display("FAIL clr_drain_hold got %h exp 3c", result); end
      tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL clr_drain_ready got %b exp 1", ready_in); end
      tick();
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL clr_drain_rv2 got %b exp 0", result_valid); end
   endtask

   task automatic test_reset_drain();
      drive(1, 1, 8'h44); tick();
      drive(0, 0, 8'h00);
      rst_n = 1'b0;
      #1;
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL rstd_rv got %b exp 0", result_valid); end
      tests++; if (result !== 8'h00) begin fails++; $display("FAIL rstd_result got %h exp 00", result); end
      tests++; if (num_out !== 16'd0) begin fails++; $display("FAIL rstd_num got %0d exp 0", num_out); end
      tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL rstd_ready got %b exp 1", ready_in); end
      tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL rstd_sat got %b exp 0", sat_flag); end
      tick();
      rst_n = 1'b1;
      tick();
      tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL rstd_rv2 got %b exp 0", result_valid); end
      drive(1, 1, 8'h81); tick();
      drive(0, 0, 8'h00); tick();
      tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL rstd_rv3 got %b exp 1", result_valid); end
      tests++; if (result !== 8'h81) begin fails++; $display("FAIL rstd_result2 got %h exp 81", result); end
      tests++; if (num_out !== 16'd1) begin fails++; $display("FAIL rstd_num2 got %0d exp 1", num_out); end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_saturation();
      test_back_to_back();
      test_clear();
      test_reset_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
